// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start, 8 data, odd parity, stop, then the device ACK.
// Latency: accept to first clock release is INHIBIT_US*CYC_US cycles; pin edge to data_oe change is at most 4 pclk.
// Backpressure: tx_ready is high only in IDLE; tx_valid while busy is dropped. Optional retries: PS2_TX_RETRY_EN.
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int unsigned CLK_HZ     = 65_000_000,
    parameter int unsigned INHIBIT_US = 120,
    parameter int unsigned TIMEOUT_US = 20000,
    parameter int unsigned RETRIES    = 2
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

`ifdef PS2_TX_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam longint unsigned CYC_US  = longint'(CLK_HZ) / 1_000_000;
    localparam longint unsigned INH_CYC = longint'(INHIBIT_US) * CYC_US;
    localparam longint unsigned TO_CYC  = longint'(TIMEOUT_US) * CYC_US;
    localparam int INH_W = $clog2(INH_CYC + 1);
    localparam int TO_W  = $clog2(TO_CYC + 1);
    localparam int RC_W  = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

    localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INH_CYC - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYC - 1);
    localparam logic [RC_W-1:0]  RETRY_MAX = RC_W'(RETRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_ACK,
        S_WAIT_IDLE,
        S_RELOAD
    } state_t;

    state_t            state_q, state_d;
    logic [9:0]        frame_q, frame_d;
    logic [7:0]        byte_q, byte_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0]  inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [RC_W-1:0]   retry_cnt_q, retry_cnt_d;
    logic              clk_oe_q, clk_oe_d;
    logic              data_oe_q, data_oe_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic              fail;

    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic data_s1_q, data_s2_q;
    logic clk_fall;

    // Two-flop synchronisers on both pins plus a history flop on the clock for fall detection.
    always_ff @(posedge pclk) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk_i;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            data_s1_q  <= ps2_data_i;
            data_s2_q  <= data_s1_q;
        end
    end

    assign clk_fall = clk_prev_q & ~clk_s2_q;

    // Next-state, counter and registered-output logic for the request sequence.
    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        byte_d      = byte_q;
        bit_cnt_d   = bit_cnt_q;
        inh_cnt_d   = inh_cnt_q;
        to_cnt_d    = to_cnt_q;
        retry_cnt_d = retry_cnt_q;
        clk_oe_d    = clk_oe_q;
        data_oe_d   = data_oe_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        fail        = 1'b0;

        // The timeout covers everything from clock release until the bus returns idle.
        if (state_q == S_REQ || state_q == S_ACK || state_q == S_WAIT_IDLE) begin
            if (to_cnt_q == TO_LAST) begin
                fail = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid && ready_q) begin
                    frame_d     = {1'b1, ~^tx_data, tx_data};
                    byte_d      = tx_data;
                    bit_cnt_d   = 4'd0;
                    inh_cnt_d   = '0;
                    to_cnt_d    = '0;
                    retry_cnt_d = '0;
                    clk_oe_d    = 1'b1;
                    state_d     = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                // Start bit goes out on the same edge the clock is released.
                if (inh_cnt_q == INH_LAST) begin
                    data_oe_d = 1'b1;
                    clk_oe_d  = 1'b0;
                    to_cnt_d  = '0;
                    state_d   = S_REQ;
                end else begin
                    inh_cnt_d = inh_cnt_q + INH_W'(1);
                end
            end
            S_REQ: begin
                if (clk_fall) begin
                    data_oe_d = ~frame_q[0];
                    frame_d   = {1'b0, frame_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (clk_fall) begin
                    if (!data_s2_q) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (clk_s2_q && data_s2_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RELOAD: begin
                frame_d   = {1'b1, ~^byte_q, byte_q};
                bit_cnt_d = 4'd0;
                inh_cnt_d = '0;
                to_cnt_d  = '0;
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b0;
                state_d   = S_INHIBIT;
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase

        // Failure releases both lines; a remaining retry goes through one released cycle first.
        if (fail) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            if (RETRY_EN && (retry_cnt_q < RETRY_MAX)) begin
                retry_cnt_d = retry_cnt_q + RC_W'(1);
                state_d     = S_RELOAD;
            end else begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
        end

        ready_d = (state_d == S_IDLE);
    end

    // State and registered outputs; reset releases both lines on the reset edge.
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            frame_q     <= '0;
            byte_q      <= '0;
            bit_cnt_q   <= '0;
            inh_cnt_q   <= '0;
            to_cnt_q    <= '0;
            retry_cnt_q <= '0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            byte_q      <= byte_d;
            bit_cnt_q   <= bit_cnt_d;
            inh_cnt_q   <= inh_cnt_d;
            to_cnt_q    <= to_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
        end
    end

    assign tx_ready    = ready_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule
